// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encodings and
// the sizing helper for the handshake timeout counter.
package multicycle_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_FAULT  = 3'd7
  } state_e;

  // A zero limit still needs a 1-bit counter so the port widths stay legal.
  function automatic int timer_width(input int limit);
    if (limit < 1) begin
      return 1;
    end else begin
      return $clog2(limit + 1);
    end
  endfunction

endpackage

// File: rtl/multicycle_sequencer_handshake_timer.sv
// Clearable saturating wait counter; o_expired flags the wait cycle that
// uses up the budget, so the owner can leave on that same edge.
module multicycle_sequencer_handshake_timer
  import multicycle_sequencer_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);

  localparam int CNT_W = timer_width(LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_count;

  // Count wait cycles, saturating at the limit; clear has priority.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_count_en && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  // A limit of zero disables the timeout entirely.
  assign o_expired = (LIMIT != 0) && i_count_en && (r_count == (CNT_MAX - CNT_W'(1)));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle PC/fetch/control sequencer: FETCH->DECODE->EXEC->(MEM)->(WB)
// with ready handshakes to instruction and data memories.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h0040_0000),
  parameter int              PC_STEP     = 4,
  parameter int              MEM_TIMEOUT = 255
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            halt_in,
  output logic            imem_req_out,
  output logic [XLEN-1:0] imem_addr_out,
  input  logic            imem_ready_in,
  input  logic [31:0]     imem_data_in,
  output logic [31:0]     ir_out,
  input  logic            dec_regwrite_in,
  input  logic            dec_memread_in,
  input  logic            dec_memwrite_in,
  input  logic            dec_branch_in,
  input  logic            dec_jump_in,
  input  logic            alu_taken_in,
  input  logic [XLEN-1:0] target_in,
  output logic            dmem_rden_out,
  output logic            dmem_wren_out,
  input  logic            dmem_ready_in,
  output logic            regwrite_out,
  output logic            retired_out,
  output logic [XLEN-1:0] pc_out,
  output logic [2:0]      state_out,
  output logic            fault_out
);

  state_e            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_npc;
  logic [31:0]       r_ir;
  logic              r_imem_req;
  logic              r_dmem_rden;
  logic              r_dmem_wren;
  logic              r_regwrite;
  logic              r_retired;
  logic              r_fault;

  logic              w_wait;
  logic              w_expired;
  logic              w_redirect;
  logic [XLEN-1:0]   w_npc;

  // Next-PC selection, only consumed while in EXEC.
  always_comb begin
    w_redirect = dec_jump_in | (dec_branch_in & alu_taken_in);
    if (w_redirect) begin
      w_npc = target_in;
    end else begin
      w_npc = r_pc + XLEN'(PC_STEP);
    end
  end

  // A wait cycle is an outstanding request whose ready has not arrived.
  always_comb begin
    w_wait = 1'b0;
    case (r_state)
      ST_FETCH: w_wait = r_imem_req & ~imem_ready_in;
      ST_MEM:   w_wait = (r_dmem_rden | r_dmem_wren) & ~dmem_ready_in;
      default:  w_wait = 1'b0;
    endcase
  end

  multicycle_sequencer_handshake_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .i_clear    (~w_wait),
    .i_count_en (w_wait),
    .o_expired  (w_expired)
  );

  // Sequencer FSM; strobes are registered so each is set on the edge that enters its state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_npc       <= '0;
      r_ir        <= 32'h0000_0000;
      r_imem_req  <= 1'b0;
      r_dmem_rden <= 1'b0;
      r_dmem_wren <= 1'b0;
      r_regwrite  <= 1'b0;
      r_retired   <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_regwrite <= 1'b0;
      r_retired  <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          // halt only gates a new request; an issued fetch is allowed to complete
          if (!r_imem_req) begin
            r_imem_req <= ~halt_in;
          end else if (imem_ready_in) begin
            r_ir       <= imem_data_in;
            r_imem_req <= 1'b0;
            r_state    <= ST_DECODE;
          end else if (w_expired) begin
            r_imem_req <= 1'b0;
            r_fault    <= 1'b1;
            r_state    <= ST_FAULT;
          end else begin
            r_imem_req <= 1'b1;
          end
        end
        ST_DECODE: begin
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_npc <= w_npc;
          if (dec_memread_in && dec_memwrite_in) begin
            r_fault <= 1'b1;
            r_state <= ST_FAULT;
          end else if (dec_memread_in || dec_memwrite_in) begin
            r_dmem_rden <= dec_memread_in;
            r_dmem_wren <= dec_memwrite_in;
            r_state     <= ST_MEM;
          end else if (dec_regwrite_in) begin
            r_regwrite <= 1'b1;
            r_state    <= ST_WB;
          end else begin
            r_pc       <= w_npc;
            r_retired  <= 1'b1;
            r_imem_req <= ~halt_in;
            r_state    <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (dmem_ready_in) begin
            r_dmem_rden <= 1'b0;
            r_dmem_wren <= 1'b0;
            if (r_dmem_rden && dec_regwrite_in) begin
              r_regwrite <= 1'b1;
              r_state    <= ST_WB;
            end else begin
              r_pc       <= r_npc;
              r_retired  <= 1'b1;
              r_imem_req <= ~halt_in;
              r_state    <= ST_FETCH;
            end
          end else if (w_expired) begin
            r_dmem_rden <= 1'b0;
            r_dmem_wren <= 1'b0;
            r_fault     <= 1'b1;
            r_state     <= ST_FAULT;
          end else begin
            r_dmem_rden <= r_dmem_rden;
            r_dmem_wren <= r_dmem_wren;
          end
        end
        ST_WB: begin
          r_pc       <= r_npc;
          r_retired  <= 1'b1;
          r_imem_req <= ~halt_in;
          r_state    <= ST_FETCH;
        end
        ST_FAULT: begin
          r_imem_req  <= 1'b0;
          r_dmem_rden <= 1'b0;
          r_dmem_wren <= 1'b0;
          r_fault     <= 1'b1;
          r_state     <= ST_FAULT;
        end
        default: begin
          r_imem_req  <= 1'b0;
          r_dmem_rden <= 1'b0;
          r_dmem_wren <= 1'b0;
          r_fault     <= 1'b1;
          r_state     <= ST_FAULT;
        end
      endcase
    end
  end

  assign imem_req_out  = r_imem_req;
  assign imem_addr_out = r_pc;
  assign pc_out        = r_pc;
  assign ir_out        = r_ir;
  assign dmem_rden_out = r_dmem_rden;
  assign dmem_wren_out = r_dmem_wren;
  assign regwrite_out  = r_regwrite;
  assign retired_out   = r_retired;
  assign state_out     = r_state;
  assign fault_out     = r_fault;

endmodule
